// File: rtl/riscv_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//   XLEN       datapath width
//   NREG       architectural register count (x0 hardwired to zero)
//   REG_AW     register index width
//   reg_idx_t  register index type
//   xdata_t    datapath word type
//   wb_entry_t buffered load return {rd, data}
//   wb_grant_e write-port arbitration result
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xdata_t;

  typedef struct packed {
    reg_idx_t rd;
    xdata_t   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } wb_grant_e;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Signal bundle between decode / ALU / load unit / reg_file and the
// writeback scheduler.
//   issue_*       decode-stage instruction presented for issue
//   stall         issue not accepted this cycle
//   alu_wb_*      ALU writeback request (valid/ready handshake)
//   ld_*          load-return request (valid/ready handshake)
//   reg_write/RD/WriteData  registered reg_file write port
//   busy          scoreboard vector
// Modports: master = surrounding pipeline, slave = scheduler.
interface regfile_wb_scheduler_if;
  import riscv_pkg::*;

  logic            issue_valid;
  reg_idx_t        issue_rs1;
  reg_idx_t        issue_rs2;
  logic            issue_use_rs1;
  logic            issue_use_rs2;
  reg_idx_t        issue_rd;
  logic            issue_reg_wr;
  logic            issue_is_load;
  logic            stall;

  logic            alu_wb_valid;
  reg_idx_t        alu_wb_rd;
  xdata_t          alu_wb_data;
  logic            alu_wb_ready;

  logic            ld_valid;
  reg_idx_t        ld_rd;
  xdata_t          ld_data;
  logic            ld_ready;

  logic            reg_write;
  reg_idx_t        RD;
  xdata_t          WriteData;
  logic [NREG-1:0] busy;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_reg_wr, issue_is_load,
           alu_wb_valid, alu_wb_rd, alu_wb_data,
           ld_valid, ld_rd, ld_data,
    input  stall, alu_wb_ready, ld_ready, reg_write, RD, WriteData, busy
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_reg_wr, issue_is_load,
           alu_wb_valid, alu_wb_rd, alu_wb_data,
           ld_valid, ld_rd, ld_data,
    output stall, alu_wb_ready, ld_ready, reg_write, RD, WriteData, busy
  );

endinterface

// File: rtl/wb_ld_fifo.sv
// Synchronous FIFO buffering returned loads until the write port is free.
//   clk, reset  clock, synchronous active-high reset
//   push        write wr_entry (ignored while full)
//   pop         drop head (ignored while empty)
//   wr_entry    {rd, data} to store
//   head        oldest entry (valid while !empty)
//   full/empty  occupancy flags
module wb_ld_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t wr_entry,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count/pointers alone decide what
  // is valid, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler and RAW/WAW scoreboard.
//   clk, reset  clock, synchronous active-high reset
//   bus         regfile_wb_scheduler_if.slave: issue/stall, ALU writeback,
//               load return, registered reg_file write port, busy vector
// Parameters:
//   LD_FIFO_DEPTH  load-return buffer entries (>=1)
//   LD_MAX         loads issued but not yet returned before issue stalls
module regfile_wb_scheduler
  import riscv_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 2,
  parameter int LD_MAX        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(LD_MAX + 1);

  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [CNT_W-1:0] ld_cnt_q;
  logic             hazard;
  logic             accept;
  logic             ld_inc;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  wb_entry_t        fifo_head;

  wb_grant_e        grant;
  reg_idx_t         win_rd;
  xdata_t           win_data;

  logic             reg_write_q;
  reg_idx_t         rd_q;
  xdata_t           wdata_q;

  // Scoreboard / issue. busy[0] is never set, so x0 can never hazard.
  assign hazard = (bus.issue_use_rs1 & busy_q[bus.issue_rs1])
                | (bus.issue_use_rs2 & busy_q[bus.issue_rs2])
                | (bus.issue_reg_wr  & busy_q[bus.issue_rd])
                | (bus.issue_is_load & (ld_cnt_q == CNT_W'(LD_MAX)));
  assign bus.stall = bus.issue_valid & hazard;
  assign accept    = bus.issue_valid & ~hazard;
  assign ld_inc    = accept & bus.issue_is_load;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    busy_d = busy_q;
    // Clear on the same edge reg_file is written; the set comes after so
    // it wins should both ever target one index.
    if (reg_write_q) busy_d[rd_q] = 1'b0;
    if (accept && bus.issue_reg_wr && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
  end

  // Load-return buffer. The full FIFO never accepts, even while popping.
  assign bus.ld_ready = ~fifo_full;
  assign fifo_push    = bus.ld_valid & ~fifo_full;
  assign fifo_pop     = (grant == GNT_LD);

  wb_ld_fifo #(
    .DEPTH (LD_FIFO_DEPTH)
  ) u_ld_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wr_entry ('{rd: bus.ld_rd, data: bus.ld_data}),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Arbitration: a full buffer must drain before the ALU may write again,
  // otherwise load returns would back up into the memory pipeline.
  assign bus.alu_wb_ready = ~fifo_full;

  always_comb begin
    grant    = GNT_NONE;
    win_rd   = '0;
    win_data = '0;
    if (fifo_full) begin
      grant = GNT_LD;
    end else if (bus.alu_wb_valid) begin
      grant = GNT_ALU;
    end else if (!fifo_empty) begin
      grant = GNT_LD;
    end
    case (grant)
      GNT_ALU: begin
        win_rd   = bus.alu_wb_rd;
        win_data = bus.alu_wb_data;
      end
      GNT_LD: begin
        win_rd   = fifo_head.rd;
        win_data = fifo_head.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      ld_cnt_q    <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
    end else begin
      busy_q <= busy_d;

      // Issue and return in one cycle cancel. A return with nothing
      // outstanding (e.g. just after reset) saturates at zero.
      if (ld_inc && !fifo_push) begin
        ld_cnt_q <= ld_cnt_q + CNT_W'(1);
      end else if (!ld_inc && fifo_push && (ld_cnt_q != '0)) begin
        ld_cnt_q <= ld_cnt_q - CNT_W'(1);
      end

      // A winner targeting x0 is consumed but never written.
      reg_write_q <= (grant != GNT_NONE) && (win_rd != '0);
      if (grant != GNT_NONE) begin
        rd_q    <= win_rd;
        wdata_q <= win_data;
      end
    end
  end

  assign bus.reg_write = reg_write_q;
  assign bus.RD        = rd_q;
  assign bus.WriteData = wdata_q;
  assign bus.busy      = busy_q;

  ld_protocol_a : assert property (@(posedge clk) disable iff (reset)
    !(bus.ld_valid && !bus.ld_ready))
    else $error("ld_valid raised while ld_ready is low");

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed, table-driven bench for regfile_wb_scheduler. Each record is one
// clock cycle: inputs applied after the falling edge, outputs compared 1ns
// later (registered outputs therefore reflect all earlier records).
module tb_regfile_wb_scheduler;
  import riscv_pkg::*;

  typedef struct packed {
    logic            rst;
    logic            iv;
    reg_idx_t        rs1;
    logic            u1;
    reg_idx_t        rs2;
    logic            u2;
    reg_idx_t        rd;
    logic            rw;
    logic            ld;
    logic            av;
    reg_idx_t        ard;
    xdata_t          adata;
    logic            lv;
    reg_idx_t        lrd;
    xdata_t          ldata;
    logic            e_stall;
    logic            e_aready;
    logic            e_lready;
    logic            e_rw;
    reg_idx_t        e_rd;
    xdata_t          e_wd;
    logic [NREG-1:0] e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler #(
    .LD_FIFO_DEPTH (2),
    .LD_MAX        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- record builders ----------------
  function automatic vec_t v0();
    vec_t v = '0;
    v.e_aready = 1'b1;
    v.e_lready = 1'b1;
    return v;
  endfunction

  function automatic vec_t with_rst(input vec_t v);
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t iss(input vec_t v, input int rs1, input int u1,
                               input int rs2, input int u2, input int rd,
                               input int rw, input int ld);
    v.iv  = 1'b1;
    v.rs1 = REG_AW'(rs1);
    v.u1  = u1[0];
    v.rs2 = REG_AW'(rs2);
    v.u2  = u2[0];
    v.rd  = REG_AW'(rd);
    v.rw  = rw[0];
    v.ld  = ld[0];
    return v;
  endfunction

  function automatic vec_t alu(input vec_t v, input int rd, input xdata_t d);
    v.av    = 1'b1;
    v.ard   = REG_AW'(rd);
    v.adata = d;
    return v;
  endfunction

  function automatic vec_t ldr(input vec_t v, input int rd, input xdata_t d);
    v.lv    = 1'b1;
    v.lrd   = REG_AW'(rd);
    v.ldata = d;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t v, input int stall, input int aready,
                              input int lready, input int rw, input int rd,
                              input xdata_t wd, input logic [NREG-1:0] busy);
    v.e_stall  = stall[0];
    v.e_aready = aready[0];
    v.e_lready = lready[0];
    v.e_rw     = rw[0];
    v.e_rd     = REG_AW'(rd);
    v.e_wd     = wd;
    v.e_busy   = busy;
    return v;
  endfunction

  // ---------------- drive / compare ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset             = v.rst;
    bus.issue_valid   = v.iv;
    bus.issue_rs1     = v.rs1;
    bus.issue_use_rs1 = v.u1;
    bus.issue_rs2     = v.rs2;
    bus.issue_use_rs2 = v.u2;
    bus.issue_rd      = v.rd;
    bus.issue_reg_wr  = v.rw;
    bus.issue_is_load = v.ld;
    bus.alu_wb_valid  = v.av;
    bus.alu_wb_rd     = v.ard;
    bus.alu_wb_data   = v.adata;
    bus.ld_valid      = v.lv;
    bus.ld_rd         = v.lrd;
    bus.ld_data       = v.ldata;
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, " stall"},        64'(bus.stall),        64'(v.e_stall));
    check({tag, " alu_wb_ready"}, 64'(bus.alu_wb_ready), 64'(v.e_aready));
    check({tag, " ld_ready"},     64'(bus.ld_ready),     64'(v.e_lready));
    check({tag, " reg_write"},    64'(bus.reg_write),    64'(v.e_rw));
    check({tag, " busy"},         64'(bus.busy),         64'(v.e_busy));
    if (v.e_rw) begin
      check({tag, " RD"},        64'(bus.RD),   64'(v.e_rd));
      check({tag, " WriteData"}, bus.WriteData, v.e_wd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    vec_t v;
    drive(with_rst(v0()));

    // Reset with ld_valid high is ignored; x0 / idle behaviour; RAW stall
    // until the cycle after the RD=5 write; ALU beats a same-cycle load
    // which follows one cycle later; ALU write to x0 is dropped.
    tbl.push_back(ex(ldr(with_rst(v0()), 9, 64'h99),        0, 1, 1, 0, 0, 0,          32'h0));
    tbl.push_back(ex(iss(v0(), 9, 1, 0, 0, 0, 0, 0),         0, 1, 1, 0, 0, 0,          32'h0));
    tbl.push_back(ex(v0(),                                   0, 1, 1, 0, 0, 0,          32'h0));
    tbl.push_back(ex(iss(v0(), 0, 0, 0, 0, 5, 1, 0),         0, 1, 1, 0, 0, 0,          32'h0));
    tbl.push_back(ex(alu(iss(v0(), 5, 1, 0, 0, 6, 1, 0), 5, 64'h55),
                                                             1, 1, 1, 0, 0, 0,          32'h20));
    tbl.push_back(ex(iss(v0(), 5, 1, 0, 0, 6, 1, 0),         1, 1, 1, 1, 5, 64'h55,     32'h20));
    tbl.push_back(ex(iss(v0(), 5, 1, 0, 0, 6, 1, 0),         0, 1, 1, 0, 0, 0,          32'h0));
    tbl.push_back(ex(ldr(alu(v0(), 3, 64'h33), 7, 64'h77),   0, 1, 1, 0, 0, 0,          32'h40));
    tbl.push_back(ex(v0(),                                   0, 1, 1, 1, 3, 64'h33,     32'h40));
    tbl.push_back(ex(alu(v0(), 6, 64'h66),                   0, 1, 1, 1, 7, 64'h77,     32'h40));
    tbl.push_back(ex(v0(),                                   0, 1, 1, 1, 6, 64'h66,     32'h40));
    tbl.push_back(ex(alu(iss(v0(), 0, 1, 0, 1, 0, 1, 0), 0, 64'hAB),
                                                             0, 1, 1, 0, 0, 0,          32'h0));
    tbl.push_back(ex(v0(),                                   0, 1, 1, 0, 0, 0,          32'h0));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Fill the buffer while the ALU keeps requesting: a full buffer drains
    // its head first with alu_wb_ready low, then the ALU is written.
    step(ex(ldr(alu(v0(), 10, 64'hA0), 11, 64'hB1), 0, 1, 1, 0, 0,  64'h0,  32'h0), "fill_a");
    step(ex(ldr(alu(v0(), 13, 64'hA3), 12, 64'hB2), 0, 1, 1, 1, 10, 64'hA0, 32'h0), "fill_b");
    step(ex(alu(v0(), 14, 64'hA4),                  0, 0, 0, 1, 13, 64'hA3, 32'h0), "fill_c");
    step(ex(ldr(alu(v0(), 14, 64'hA4), 15, 64'hB5), 0, 1, 1, 1, 11, 64'hB1, 32'h0), "fill_d");
    step(ex(alu(v0(), 16, 64'hA6),                  0, 0, 0, 1, 14, 64'hA4, 32'h0), "fill_e");
    step(ex(alu(v0(), 16, 64'hA6),                  0, 1, 1, 1, 12, 64'hB2, 32'h0), "fill_f");
    step(ex(v0(),                                   0, 1, 1, 1, 16, 64'hA6, 32'h0), "fill_g");
    step(ex(v0(),                                   0, 1, 1, 1, 15, 64'hB5, 32'h0), "fill_h");
    step(ex(v0(),                                   0, 1, 1, 0, 0,  64'h0,  32'h0), "fill_i");

    // Outstanding-load limit: four loads accepted, fifth stalls until one
    // return brings the count back to three.
    for (int k = 0; k < 4; k++) begin
      step(ex(iss(v0(), 0, 0, 0, 0, 20 + k, 1, 1), 0, 1, 1, 0, 0, 64'h0,
              ((32'h1 << k) - 32'h1) << 20), $sformatf("ldmax_issue%0d", k));
    end
    step(ex(iss(v0(), 0, 0, 0, 0, 24, 1, 1),               1, 1, 1, 0, 0,  64'h0,  32'h00F0_0000), "ldmax_5th");
    step(ex(ldr(iss(v0(), 0, 0, 0, 0, 24, 1, 1), 20, 64'hC0),
                                                           1, 1, 1, 0, 0,  64'h0,  32'h00F0_0000), "ldmax_ret");
    step(ex(iss(v0(), 0, 0, 0, 0, 24, 1, 1),               0, 1, 1, 0, 0,  64'h0,  32'h00F0_0000), "ldmax_go");
    step(ex(v0(),                                          0, 1, 1, 1, 20, 64'hC0, 32'h01F0_0000), "ldmax_wb");
    step(ex(iss(v0(), 0, 0, 0, 0, 25, 1, 1),               1, 1, 1, 0, 0,  64'h0,  32'h01E0_0000), "ldmax_again");

    // Reset mid-operation drops the buffered load, the scoreboard and the
    // outstanding-load count (four new loads are accepted again).
    step(ex(ldr(v0(), 21, 64'hD1),                         0, 1, 1, 0, 0,  64'h0,  32'h01E0_0000), "mid_push");
    step(ex(with_rst(v0()),                                0, 1, 1, 0, 0,  64'h0,  32'h01E0_0000), "mid_reset");
    for (int k = 0; k < 4; k++) begin
      step(ex(iss(v0(), 0, 0, 0, 0, 1 + k, 1, 1), 0, 1, 1, 0, 0, 64'h0,
              ((32'h1 << k) - 32'h1) << 1), $sformatf("post_rst_ld%0d", k));
    end
    step(ex(iss(v0(), 0, 0, 0, 0, 5, 1, 1),                1, 1, 1, 0, 0,  64'h0,  32'h1E), "post_rst_limit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
